// File: rtl/musk_scoreboard_pkg.sv
// Register identifiers and scoreboard types shared by the musk scoreboard slice.
// Only the architectural file (rax..r15) is tracked; the pseudo ids never count.
package musk_scoreboard_pkg;

    typedef enum logic [4:0] {
        rnil, rip, rimm, rv0, rv8, rsyscall,
        rax, rbx, rcx, rdx, rsi, rdi, rsp, rbp,
        r8, r9, r10, r11, r12, r13, r14, r15
    } reg_id_t;

    localparam int REG_FILE_SIZE = 16;
    localparam int RNUM_W        = 4;
    localparam int SB_CNT_W      = 2;
    localparam int SB_CNT_MAX    = (1 << SB_CNT_W) - 1;

    typedef logic [SB_CNT_W-1:0] sb_cnt_t;
    typedef logic [RNUM_W-1:0]   reg_num_t;

    function automatic logic reg_in_file(input reg_id_t id);
        return 5'(id) >= 5'(rax);
    endfunction

    function automatic reg_num_t reg_num(input reg_id_t id);
        logic [4:0] d;
        d = 5'(id) - 5'(rax);
        return d[RNUM_W-1:0];
    endfunction

endpackage

// File: rtl/musk_sb_grant.sv
// In-order issue grant chain: a stalled slot blocks every younger slot, and
// older same-cycle grants are folded into RAW/WAW checks through pend[].
module musk_sb_grant
    import musk_scoreboard_pkg::*;
#(
    parameter int REGS      = REG_FILE_SIZE,
    parameter int ISSUE_W   = 2,
    parameter int CNT_W     = SB_CNT_W,
    parameter int WAW_ALLOW = 1
) (
    input  logic [CNT_W-1:0]          eff [REGS],
    input  logic                      kill,
    input  logic [ISSUE_W-1:0]        iss_valid,
    input  reg_id_t [ISSUE_W-1:0]     iss_src0,
    input  reg_id_t [ISSUE_W-1:0]     iss_src1,
    input  reg_id_t [ISSUE_W-1:0]     iss_dst,
    output logic [ISSUE_W-1:0]        iss_grant
);
    localparam int MAX = (1 << CNT_W) - 1;
    localparam int PW  = CNT_W + 2;

    logic [PW-1:0] pend [REGS];
    logic          blocked;
    logic          ok;
    logic          sys;
    logic          all_zero;
    reg_id_t       src;
    reg_num_t      n;

    always_comb begin
        all_zero  = 1'b1;
        blocked   = kill;
        iss_grant = '0;
        ok        = 1'b0;
        sys       = 1'b0;
        src       = rnil;
        n         = '0;
        for (int r = 0; r < REGS; r++) begin
            pend[r] = '0;
            if (eff[r] != '0) all_zero = 1'b0;
        end
        for (int i = 0; i < ISSUE_W; i++) begin
            ok  = iss_valid[i] && !blocked;
            sys = 1'b0;
            for (int s = 0; s < 2; s++) begin
                src = (s == 0) ? iss_src0[i] : iss_src1[i];
                if (src == rsyscall) begin
                    sys = 1'b1;
                    if (i != 0 || !all_zero) ok = 1'b0;
                end else if (reg_in_file(src)) begin
                    n = reg_num(src);
                    if (eff[n] != '0 || pend[n] != '0) ok = 1'b0;
                end
            end
            if (reg_in_file(iss_dst[i])) begin
                n = reg_num(iss_dst[i]);
                if (WAW_ALLOW != 0) begin
                    if ({2'b00, eff[n]} + pend[n] >= PW'(MAX)) ok = 1'b0;
                end else if (eff[n] != '0 || pend[n] != '0) begin
                    ok = 1'b0;
                end
                if (ok) pend[n] = pend[n] + 1'b1;
            end
            iss_grant[i] = ok;
            // a syscall serialises: nothing younger may issue alongside it
            if (!ok || sys) blocked = 1'b1;
        end
    end

endmodule

// File: rtl/musk_scoreboard.sv
// Multi-issue register scoreboard: saturating per-register in-flight writer
// counters, in-order grant, writeback credit, flush and sticky underflow flag.
module musk_scoreboard
    import musk_scoreboard_pkg::*;
#(
    parameter int REGS      = REG_FILE_SIZE,
    parameter int ISSUE_W   = 2,
    parameter int WB_W      = 2,
    parameter int CNT_W     = SB_CNT_W,
    parameter int WAW_ALLOW = 1,
    parameter int WB_BYPASS = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic [ISSUE_W-1:0]    iss_valid,
    input  reg_id_t [ISSUE_W-1:0] iss_src0,
    input  reg_id_t [ISSUE_W-1:0] iss_src1,
    input  reg_id_t [ISSUE_W-1:0] iss_dst,
    output logic [ISSUE_W-1:0]    iss_grant,
    input  logic [WB_W-1:0]       wb_valid,
    input  reg_id_t [WB_W-1:0]    wb_dst,
    output logic [REGS-1:0]       busy_mask,
    output logic                  sb_empty,
    output logic                  err_uflow
);
    localparam int MAX = (1 << CNT_W) - 1;
    localparam int DW  = CNT_W + 2;

    logic [CNT_W-1:0] count   [REGS];
    logic [CNT_W-1:0] eff     [REGS];
    logic [CNT_W-1:0] cnt_nxt [REGS];
    logic [DW-1:0]    wb_hits [REGS];
    logic [DW-1:0]    iss_hits[REGS];
    logic [DW-1:0]    sum;
    logic [REGS-1:0]  busy_nxt;
    logic             uflow_nxt;

    always_comb begin
        for (int r = 0; r < REGS; r++) wb_hits[r] = '0;
        for (int j = 0; j < WB_W; j++)
            if (wb_valid[j] && reg_in_file(wb_dst[j]))
                wb_hits[reg_num(wb_dst[j])] = wb_hits[reg_num(wb_dst[j])] + 1'b1;
    end

    always_comb begin
        for (int r = 0; r < REGS; r++) begin
            eff[r] = count[r];
            if (WB_BYPASS != 0) begin
                if (DW'(count[r]) <= wb_hits[r]) eff[r] = '0;
                else                             eff[r] = count[r] - wb_hits[r][CNT_W-1:0];
            end
        end
    end

    musk_sb_grant #(
        .REGS      (REGS),
        .ISSUE_W   (ISSUE_W),
        .CNT_W     (CNT_W),
        .WAW_ALLOW (WAW_ALLOW)
    ) u_grant (
        .eff       (eff),
        .kill      (reset | flush),
        .iss_valid (iss_valid),
        .iss_src0  (iss_src0),
        .iss_src1  (iss_src1),
        .iss_dst   (iss_dst),
        .iss_grant (iss_grant)
    );

    always_comb begin
        for (int r = 0; r < REGS; r++) iss_hits[r] = '0;
        for (int i = 0; i < ISSUE_W; i++)
            if (iss_grant[i] && reg_in_file(iss_dst[i]))
                iss_hits[reg_num(iss_dst[i])] = iss_hits[reg_num(iss_dst[i])] + 1'b1;
    end

    // two's-complement sum at DW bits; a set sign bit means net underflow
    always_comb begin
        uflow_nxt = 1'b0;
        sum       = '0;
        for (int r = 0; r < REGS; r++) begin
            sum = {2'b00, count[r]} + iss_hits[r] - wb_hits[r];
            if (sum[DW-1]) begin
                cnt_nxt[r] = '0;
                uflow_nxt  = 1'b1;
            end else if (sum > DW'(MAX)) begin
                cnt_nxt[r] = CNT_W'(MAX);
            end else begin
                cnt_nxt[r] = sum[CNT_W-1:0];
            end
            busy_nxt[r] = (cnt_nxt[r] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < REGS; r++) count[r] <= '0;
            busy_mask <= '0;
            sb_empty  <= 1'b1;
            err_uflow <= 1'b0;
        end else if (flush) begin
            for (int r = 0; r < REGS; r++) count[r] <= '0;
            busy_mask <= '0;
            sb_empty  <= 1'b1;
        end else begin
            for (int r = 0; r < REGS; r++) count[r] <= cnt_nxt[r];
            busy_mask <= busy_nxt;
            sb_empty  <= ~|busy_nxt;
            err_uflow <= err_uflow | uflow_nxt;
        end
    end

endmodule
